// File: rtl/scope_trigger.sv
// scope_trigger: arm / trigger / capture controller feeding the 64-bit trace scope.
// It waits for a masked level or edge match on the probe bus, optionally skipping
// trig_count qualifying events, then holds o_trace_en for CAPTURE_LEN cycles. During
// that window it presents the twice-pipelined probe word, optionally stamped with a
// 16-bit cycle count since the trigger.
//
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_probe[63:0]         signals under observation
//   i_arm                 arm request pulse (also re-arms while ARMED)
//   i_force_trig          immediate trigger while ARMED
//   i_trig_mask/value     match condition: ((p1 ^ value) & mask) == 0
//   i_trig_edge           0 = level match, 1 = rising edge of match
//   i_trig_count[7:0]     qualifying events to skip before firing
//   o_trace_in[63:0]      registered word to the scope (0 outside CAPTURE)
//   o_trace_en            capture window
//   o_armed, o_done       state decodes
module scope_trigger #(
  parameter int CAPTURE_LEN = 16384,
  parameter bit TS_EN       = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [63:0] i_probe,
  input  logic        i_arm,
  input  logic        i_force_trig,
  input  logic [63:0] i_trig_mask,
  input  logic [63:0] i_trig_value,
  input  logic        i_trig_edge,
  input  logic [7:0]  i_trig_count,
  output logic [63:0] o_trace_in,
  output logic        o_trace_en,
  output logic        o_armed,
  output logic        o_done
);
  localparam int LW = (CAPTURE_LEN > 1) ? $clog2(CAPTURE_LEN) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DONE} state_t;

  state_t      r_state, w_state_nxt;
  logic [63:0] r_p1;
  logic [63:0] r_trace_in;
  logic        r_mprev;
  logic [7:0]  r_hits;
  logic [LW-1:0] r_len;
  logic [15:0] r_ts;

  logic        w_match, w_qev, w_fire, w_arm_take, w_cap_nxt;
  logic [15:0] w_ts_nxt;
  logic [63:0] w_word;

  assign w_match = ((r_p1 ^ i_trig_value) & i_trig_mask) == 64'd0;
  assign w_qev   = i_trig_edge ? (w_match & ~r_mprev) : w_match;
  assign w_fire  = (r_state == S_ARMED) &
                   (i_force_trig | (w_qev & (r_hits == i_trig_count)));
  // Arm is honoured from IDLE/DONE and as a re-arm in ARMED, unless firing wins.
  assign w_arm_take = i_arm & ((r_state == S_IDLE) | (r_state == S_DONE) |
                               ((r_state == S_ARMED) & ~w_fire));

  assign w_cap_nxt = (w_state_nxt == S_CAPTURE);
  assign w_ts_nxt  = (r_state == S_CAPTURE) ? r_ts + 16'd1 : 16'd0;
  // trace_in is loaded from p1 so it equals p2 on the cycle it is presented;
  // the second probe stage is folded into this register.
  assign w_word    = TS_EN ? {w_ts_nxt, r_p1[47:0]} : r_p1;

  // FSM: state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (i_arm)          w_state_nxt = S_ARMED;
      S_ARMED:   if (w_fire)         w_state_nxt = S_CAPTURE;
      S_CAPTURE: if (r_len == '0)    w_state_nxt = S_DONE;
      S_DONE:    if (i_arm)          w_state_nxt = S_ARMED;
      default:                       w_state_nxt = S_IDLE;
    endcase
  end

  // FSM: outputs, pure decodes of registered state
  always_comb begin
    o_trace_en = (r_state == S_CAPTURE);
    o_armed    = (r_state == S_ARMED);
    o_done     = (r_state == S_DONE);
    o_trace_in = r_trace_in;
  end

  // Datapath
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_p1       <= '0;
      r_trace_in <= '0;
      r_mprev    <= 1'b0;
      r_hits     <= '0;
      r_len      <= '0;
      r_ts       <= '0;
    end else begin
      r_p1 <= i_probe;
      // Forcing mprev on arm keeps an already-true condition from looking like an edge.
      r_mprev <= w_arm_take ? 1'b1 : w_match;

      if (w_arm_take)
        r_hits <= '0;
      else if ((r_state == S_ARMED) && w_qev && !w_fire)
        r_hits <= r_hits + 8'd1;

      if (w_fire)
        r_len <= LW'(CAPTURE_LEN - 1);
      else if ((r_state == S_CAPTURE) && (r_len != '0))
        r_len <= r_len - LW'(1);

      if (w_cap_nxt) r_ts <= w_ts_nxt;

      r_trace_in <= w_cap_nxt ? w_word : 64'd0;
    end
  end

endmodule

// File: doc/scope_trigger.md
# scope_trigger

Trigger and capture controller directly upstream of the 64-bit trace scope. It samples a 64-bit probe bus and waits, once armed, for a masked match/edge condition (optionally the Nth occurrence). It then drives `trace_en` high for exactly `CAPTURE_LEN` cycles, presenting the pipelined probe word, optionally stamped with a cycle count since trigger, on `trace_in`. When `trace_en` falls, the scope switches to UART playback; this block parks in DONE until re-armed.

## Interface
- `CAPTURE_LEN`, default 16384: cycles `trace_en` stays high; legal range 1..16384 (the scope holds 16K words).
- `TS_EN`, default 1: 1 replaces `trace_in[63:48]` with a 16-bit timestamp; 0 passes all 64 probe bits.
- `clk` in 1: single clock, all logic on posedge.
- `rst_n` in 1: asynchronous, active-low reset.
- `probe` in 64: signals under observation, synchronous to `clk`.
- `arm` in 1: single-cycle pulse requesting arm.
- `force_trig` in 1: immediate trigger while ARMED.
- `trig_mask` in 64: bit participates in match when 1.
- `trig_value` in 64: required value of masked bits.
- `trig_edge` in 1: 0 = level match, 1 = rising edge of match.
- `trig_count` in 8: number of qualifying events to skip before firing (0 = first).
- `trace_in` out 64: word to scope.
- `trace_en` out 1: capture window to scope.
- `armed` out 1: state == ARMED.
- `done` out 1: state == DONE.

## Operation
- Pipeline: `p1 <= probe`, `p2 <= p1` every cycle regardless of state.
- `match = ((p1 ^ trig_value) & trig_mask) == 0`. All-zero mask matches every cycle.
- `mprev` register: `mprev <= match` every cycle. On entry to ARMED, `mprev` is set to 1, so a condition already true at arm time does not fire in edge mode.
- Qualifying event `qev = trig_edge ? (match & ~mprev) : match`.
- `hits`, 8-bit: cleared on entry to ARMED and incremented on each `qev` in ARMED that does not fire. Fire when `qev & (hits == trig_count)`, or when `force_trig`.
- States and transitions:
  - IDLE: `arm` -> ARMED.
  - ARMED: fire -> CAPTURE; `arm` -> ARMED (re-arm: `hits` cleared, `mprev` set). Fire wins over a simultaneous `arm`.
  - CAPTURE: `trace_en` = 1. `len` counter loads `CAPTURE_LEN-1` on fire and decrements each cycle. At `len == 0`, go to DONE. `arm` and `force_trig` are ignored.
  - DONE: `arm` -> ARMED. `force_trig` is ignored.
- `trace_in` is registered. In CAPTURE it is `{ts, p2[47:0]}` when `TS_EN`, else `p2`. Outside CAPTURE it is 0.
- `ts`, 16-bit: 0 on the first CAPTURE cycle, +1 per cycle, wraps 0xFFFF -> 0.
- `trace_en`, `armed` and `done` are decoded registered state, with no combinational path from inputs.
- Reset (async, any time): state IDLE; `trace_en` = 0, `trace_in` = 0, `armed` = 0, `done` = 0; `p1`, `p2`, `mprev`, `hits`, `len`, `ts` = 0.
- Reset mid-CAPTURE drops `trace_en` immediately. The scope then plays back a partial buffer; this is accepted behaviour.

## Timing
- Let the probe word X be sampled into `p1` at edge E0 and make `qev` true in ARMED. At E1, state = CAPTURE, `trace_en` = 1, and `trace_in` holds X (timestamp 0).
- The scope writes address 0 at E2 with X. Trigger-sample latency from the probe pins is 2 cycles to `trace_in`.
- `trace_en` is high for exactly `CAPTURE_LEN` consecutive cycles. The next cycle has `trace_en` = 0 and `done` = 1.
- `force_trig` at edge E0 in ARMED gives `trace_en` = 1 at E1; the first word is `p2` at that edge.
- `arm` is sampled once per edge and is level-insensitive beyond that: a held `arm` re-arms every cycle while ARMED.
- `CAPTURE_LEN == 1`: one cycle of `trace_en`, then DONE.

## Test plan
- Reset, then `arm`; `probe` = 0x0000_0000_0000_00A5; mask 0xFF, value 0xA5, level -> `trace_en` rises 2 cycles after `probe` change and stays high exactly 16384 cycles. Scope word 0 = {16'h0000, 48'hA5}, word 5 `ts` = 5. Then `done` = 1.
- Edge mode: `probe` matches before `arm` and stays matching -> no trigger. Drop the match for 1 cycle, then restore -> trigger on the restore sample.
- `trig_count` = 3, level=0 edge=1, match pulsed 4 times -> fires on the 4th pulse only. `hits` = 3 at fire.
- `force_trig` while IDLE and while DONE -> no effect. `force_trig` while ARMED -> `trace_en` next cycle. `arm` during CAPTURE -> capture length unchanged.
- `CAPTURE_LEN` = 1 and `TS_EN` = 0 -> single-cycle `trace_en`, `trace_in` = full 64-bit probe word, then 0.
- Assert `rst_n` low mid-CAPTURE at cycle 100 -> `trace_en`, `trace_in`, `armed`, `done` go to 0 without a clock edge. After release, state is IDLE and `arm` works normally.
